cdc_2phase_src_arb: RTL
=======================

// Module: cdc_2phase_src_arb
// PURPOSE
//   Round-robin arbiter that shares one cdc_2phase source channel between NUM_REQ
//   requesters in the source clock domain. Picks one valid requester per cycle and
//   registers its payload together with a requester ID. Presents {id, data} to the
//   crossing's src_valid_i/src_ready_i/src_data_i side, so one crossing serves many.
// PARAMETERS
//   NUM_REQ    4   number of requesters, >=2, need not be a power of two
//   DATA_WIDTH 32  payload width per requester
//   ID_WIDTH   (NUM_REQ>1 ? $clog2(NUM_REQ) : 1)  derived; do not override
// PORTS
//   clk_i        in   1                   source-domain clock
//   rst_n_i      in   1                   reset, synchronous, active-low
//   en_i         in   NUM_REQ             per-requester enable mask; 0 = never granted
//   req_valid_i  in   NUM_REQ             requester valid
//   req_ready_o  out  NUM_REQ             requester ready, one-hot or zero
//   req_data_i   in   NUM_REQ*DATA_WIDTH  packed payloads, requester i at [i*DW +: DW]
//   out_valid_o  out  1                   to cdc_2phase src_valid_i
//   out_ready_i  in   1                   from cdc_2phase src_ready_o
//   out_id_o     out  ID_WIDTH            index of requester owning out_data_o
//   out_data_o   out  DATA_WIDTH          payload; the crossing carries {out_id_o, out_data_o}
//   busy_o       out  1                   out_valid_o || any(req_valid_i & en_i)
// BEHAVIOUR
//   - Reset (rst_n_i low at clk_i edge): out_valid_o=0, out_id_o=0, out_data_o=0, ptr=0.
//     req_ready_o is forced to 0 combinationally while rst_n_i is low.
//   - Eligible set E = req_valid_i & en_i. Grant g = first index in E scanning
//     ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1. No grant if E is empty.
//   - accept = !out_valid_o || out_ready_i. The output register is a one-entry stage.
//   - req_ready_o[g] = accept && (E != 0). All other bits are 0.
//   - Requester transfer happens when req_valid_i[g] && req_ready_o[g]. On the next edge:
//     out_data_o <= req_data_i[g], out_id_o <= g, out_valid_o <= 1, ptr <= (g==NUM_REQ-1)?0:g+1.
//   - Output transfer (out_valid_o && out_ready_i) with no new grant: out_valid_o <= 0.
//   - Output transfer and new grant in the same cycle: the register is reloaded.
//     Back-to-back transfers are allowed at full rate.
//   - Latency: requester handshake to out_valid_o is 1 cycle. Throughput is 1 word/cycle
//     when out_ready_i=1. Through cdc_2phase, the actual rate is limited by the 2-phase
//     round trip.
//   - While out_valid_o=1 and out_ready_i=0: out_id_o and out_data_o are stable,
//     req_ready_o=0, ptr is unchanged.
//   - en_i and req_valid_i changes affect only future grants; a registered word is never dropped.
//   - Requesters must hold req_valid_i and data until ready. A drop without handshake is not
//     an error; the next arbitration ignores it.
//   - Fairness: each continuously eligible requester is granted within NUM_REQ grants.
//   - Ordering: words from one requester leave in acceptance order.
//   - FSM: EMPTY (out_valid_o=0) -> FULL on grant.
//     FULL -> FULL on (out_ready_i && grant) or !out_ready_i.
//     FULL -> EMPTY on (out_ready_i && !grant).
// STRUCTURE
//   - Shared package cdc_pkg: arb_state_e {ARB_EMPTY, ARB_FULL} and
//     function automatic rr_next(idx, n) for wrap-around increment.
//   - Sub-module rr_arb_core #(NUM_REQ): combinational rotating-priority pick.
//     Inputs: req vector and ptr. Outputs: one-hot grant, grant index, any.
//   - Top level: ptr register, output register and ready gating. Registers are written with
//     plain synchronous-reset always_ff, not the async dffr library cell.
// TESTING  (NUM_REQ=4, DATA_WIDTH=8, en_i=4'hF unless noted)
//   - Reset: rst_n_i low 3 cycles, all valid, out_ready_i=1 -> req_ready_o=4'b0000, out_valid_o=0,
//     out_id_o=0, out_data_o=0.
//   - Single: req 2 valid with 8'hA5 for 1 cycle, out_ready_i=1 -> req_ready_o=4'b0100, then
//     next cycle out_valid_o=1, out_id_o=2, out_data_o=8'hA5.
//   - Round robin: all 4 valid continuously, out_ready_i=1 -> out_id_o sequence 0,1,2,3,0,1
//     on consecutive cycles.
//   - Backpressure: out_valid_o=1 with id 1, out_ready_i=0 for 5 cycles -> req_ready_o=0,
//     id and data are stable. Release -> next grant is id 2.
//   - Mask and wrap: en_i=4'b1011, all valid -> ids 0,1,3,0. With ptr=3 and only req 1 valid
//     -> grant 1, then ptr=2.
//   - Integration: instantiate with cdc_2phase, src:dst clock 3:7, random valid per requester.
//     Expect per-ID order preserved, no loss, no duplication, every requester served.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared types and helpers for the cdc_2phase source-side arbiter.
package cdc_pkg;

  typedef enum logic {
    ARB_EMPTY = 1'b0,
    ARB_FULL  = 1'b1
  } arb_state_e;

  // Wrap-around increment over the range 0..n-1.
  function automatic int rr_next(int idx, int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arb_core.sv
// Combinational rotating-priority pick: first set request at or after ptr, wrapping.
module rr_arb_core #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic [ID_WIDTH-1:0] ptr_i,
  output logic [NUM_REQ-1:0]  gnt_oh_o,
  output logic [ID_WIDTH-1:0] gnt_idx_o,
  output logic                any_o
);

  int                  j;
  logic [ID_WIDTH-1:0] jj;
  logic                found;

  // Scan ptr, ptr+1, ..., wrapping; the first hit wins.
  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    j         = 0;
    jj        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jj = ID_WIDTH'(j);
      if (!found && req_i[jj]) begin
        found        = 1'b1;
        gnt_oh_o[jj] = 1'b1;
        gnt_idx_o    = jj;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/cdc_2phase_src_arb.sv
// Round-robin arbiter feeding one cdc_2phase source port from NUM_REQ requesters.
// A one-entry output register holds {id, data}; it can be reloaded in the same
// cycle it drains, so the arbiter sustains one word per cycle.
module cdc_2phase_src_arb
  import cdc_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [NUM_REQ-1:0]            en_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [ID_WIDTH-1:0]           out_id_o,
  output logic [DATA_WIDTH-1:0]         out_data_o,
  output logic                          busy_o
);

  arb_state_e            state_q, state_d;
  logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    gnt_oh;
  logic [ID_WIDTH-1:0]   gnt_idx;
  logic                  gnt_any;
  logic                  accept;
  logic                  fire;

  assign eligible = req_valid_i & en_i;

  rr_arb_core #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_core (
    .req_i     (eligible),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (gnt_oh),
    .gnt_idx_o (gnt_idx),
    .any_o     (gnt_any)
  );

  // Handshake, ready gating and next-state for the output stage and pointer.
  always_comb begin
    accept      = (state_q == ARB_EMPTY) || out_ready_i;
    fire        = accept && gnt_any;
    req_ready_o = (rst_n_i && fire) ? gnt_oh : '0;
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    data_d      = data_q;
    if (fire) begin
      state_d = ARB_FULL;
      id_d    = gnt_idx;
      data_d  = req_data_i[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
      ptr_d   = ID_WIDTH'(rr_next(int'(gnt_idx), NUM_REQ));
    end else if (state_q == ARB_FULL && out_ready_i) begin
      state_d = ARB_EMPTY;
    end
  end

  // State, pointer and output register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ARB_EMPTY;
      ptr_q   <= '0;
      id_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = (state_q == ARB_FULL);
  assign out_id_o    = id_q;
  assign out_data_o  = data_q;
  assign busy_o      = out_valid_o || (|eligible);

endmodule
